// File: rtl/kb_event_queue.sv
// Multi-source keyboard event queue: per-source holding registers, round-robin
// arbitration into a FIFO, head exposed through the ZX-Uno SCANCODE/KBSTATUS registers.
module kb_event_queue #(
  parameter int         NUM_SRC       = 2,
  parameter int         DEPTH         = 8,
  parameter logic [7:0] ADDR_SCANCODE = 8'h04,
  parameter logic [7:0] ADDR_KBSTATUS = 8'h05
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_strobe,
  input  logic [8*NUM_SRC-1:0] src_code,
  input  logic [NUM_SRC-1:0]   src_ext,
  input  logic [NUM_SRC-1:0]   src_rel,
  input  logic [7:0]           zxuno_addr,
  input  logic                 zxuno_regrd,
  input  logic                 zxuno_regwr,
  input  logic [7:0]           din,
  output logic [7:0]           scancode_dout,
  output logic                 oe_scancode,
  output logic [7:0]           kbstatus_dout,
  output logic                 oe_kbstatus,
  output logic                 evt_pending
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [11:0]          mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [AW:0]          count, count_n;
  logic [1:0]           rr_ptr, rr_ptr_n, gnt_idx;
  logic                 grant, push, pop, flush, ovf_clr, ovf_set, ovf, ovf_n;
  logic                 rd_q, kbwr_q, kbwr;
  logic [11:0]          push_data, head_n;
  logic [NUM_SRC-1:0]   hold_valid, hold_valid_n, hold_ext, hold_ext_n, hold_rel, hold_rel_n;
  logic [8*NUM_SRC-1:0] hold_code, hold_code_n;
  logic [7:0]           scancode_q, kbstatus_q;
  logic                 din_unused;

  assign oe_scancode   = (zxuno_addr == ADDR_SCANCODE) && zxuno_regrd;
  assign oe_kbstatus   = (zxuno_addr == ADDR_KBSTATUS) && zxuno_regrd;
  assign scancode_dout = scancode_q;
  assign kbstatus_dout = kbstatus_q;
  assign evt_pending   = kbstatus_q[0];
  assign din_unused    = ^din[5:0];

  // Only the first cycle of a KBSTATUS write acts; pops fire when a SCANCODE read ends.
  assign kbwr    = zxuno_regwr && (zxuno_addr == ADDR_KBSTATUS);
  assign flush   = kbwr && !kbwr_q && din[7];
  assign ovf_clr = kbwr && !kbwr_q && din[6];
  assign pop     = rd_q && !oe_scancode && (count != '0) && !flush;
  assign push    = grant && ((count != FULL_COUNT) || pop) && !flush;

  // Round-robin pick: first valid holder at/after rr_ptr, otherwise wrap to the lowest valid.
  always_comb begin
    grant     = 1'b0;
    gnt_idx   = 2'd0;
    push_data = 12'h000;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!grant && hold_valid[j] && (j >= int'(rr_ptr))) begin
        grant     = 1'b1;
        gnt_idx   = 2'(j);
        push_data = {2'(j), hold_rel[j], hold_ext[j], hold_code[8*j +: 8]};
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!grant && hold_valid[j]) begin
        grant     = 1'b1;
        gnt_idx   = 2'(j);
        push_data = {2'(j), hold_rel[j], hold_ext[j], hold_code[8*j +: 8]};
      end
    end
    rr_ptr_n = (gnt_idx == 2'(NUM_SRC-1)) ? 2'd0 : gnt_idx + 2'd1;
  end

  // Holding-register capture; a strobe into a busy holder that is not draining is an overflow.
  always_comb begin
    hold_valid_n = hold_valid;
    hold_code_n  = hold_code;
    hold_ext_n   = hold_ext;
    hold_rel_n   = hold_rel;
    ovf_set      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flush) begin
        hold_valid_n[i] = 1'b0;
      end else if (src_strobe[i]) begin
        if (hold_valid[i] && !(push && (gnt_idx == 2'(i)))) begin
          ovf_set = 1'b1;
        end else begin
          hold_valid_n[i]         = 1'b1;
          hold_code_n[8*i +: 8]   = src_code[8*i +: 8];
          hold_ext_n[i]           = src_ext[i];
          hold_rel_n[i]           = src_rel[i];
        end
      end else if (push && (gnt_idx == 2'(i))) begin
        hold_valid_n[i] = 1'b0;
      end else begin
        hold_valid_n[i] = hold_valid[i];
      end
    end
    ovf_n = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
  end

  // FIFO pointer/count update plus the head entry as it will be after this edge.
  always_comb begin
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      wr_ptr_n = push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr_n = pop  ? rd_ptr + AW'(1) : rd_ptr;
      case ({push, pop})
        2'b10:   count_n = count + (AW+1)'(1);
        2'b01:   count_n = count - (AW+1)'(1);
        default: count_n = count;
      endcase
    end
    if (count_n == '0) begin
      head_n = 12'h000;
    end else if (push && (wr_ptr == rd_ptr_n)) begin
      head_n = push_data;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // FIFO storage needs no reset; count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Control state and registered output bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= 2'd0;
      ovf        <= 1'b0;
      rd_q       <= 1'b0;
      kbwr_q     <= 1'b0;
      hold_valid <= '0;
      hold_code  <= '0;
      hold_ext   <= '0;
      hold_rel   <= '0;
      scancode_q <= 8'h00;
      kbstatus_q <= 8'h00;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      rr_ptr     <= push ? rr_ptr_n : rr_ptr;
      ovf        <= ovf_n;
      rd_q       <= oe_scancode;
      kbwr_q     <= kbwr;
      hold_valid <= hold_valid_n;
      hold_code  <= hold_code_n;
      hold_ext   <= hold_ext_n;
      hold_rel   <= hold_rel_n;
      scancode_q <= head_n[7:0];
      kbstatus_q <= {count_n == FULL_COUNT, ovf_n, head_n[11:10], 1'b0,
                     head_n[9], head_n[8], count_n != '0};
    end
  end

endmodule

// File: tb/tb_kb_event_queue.sv
// Bench for kb_event_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_kb_event_queue;

  localparam int NS  = 2;
  localparam int DEP = 8;

  logic        clk, rst_n;
  logic [1:0]  src_strobe, src_ext, src_rel;
  logic [15:0] src_code;
  logic [7:0]  zxuno_addr, din;
  logic        zxuno_regrd, zxuno_regwr;
  logic [7:0]  scancode_dout, kbstatus_dout;
  logic        oe_scancode, oe_kbstatus, evt_pending;

  int total = 0;
  int bad   = 0;

  kb_event_queue #(.NUM_SRC(NS), .DEPTH(DEP), .ADDR_SCANCODE(8'h04), .ADDR_KBSTATUS(8'h05)) dut (
    .clk(clk), .rst_n(rst_n), .src_strobe(src_strobe), .src_code(src_code),
    .src_ext(src_ext), .src_rel(src_rel), .zxuno_addr(zxuno_addr),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr), .din(din),
    .scancode_dout(scancode_dout), .oe_scancode(oe_scancode),
    .kbstatus_dout(kbstatus_dout), .oe_kbstatus(oe_kbstatus), .evt_pending(evt_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the FIFO is a plain queue, holders are arrays.
  bit [11:0] q[$];
  bit        hv[NS];
  bit [7:0]  hc[NS];
  bit        he[NS], hr[NS];
  int        rr;
  bit        m_ovf, m_rdq, m_wrq;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit oe, kbw, first, flush, clr, pop, push, set;
    int g;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < NS; i++) hv[i] = 1'b0;
      rr = 0; m_ovf = 1'b0; m_rdq = 1'b0; m_wrq = 1'b0;
      return;
    end
    oe    = (zxuno_addr == 8'h04) && zxuno_regrd;
    kbw   = zxuno_regwr && (zxuno_addr == 8'h05);
    first = kbw && !m_wrq;
    flush = first && din[7];
    clr   = first && din[6];
    pop   = m_rdq && !oe && (q.size() > 0) && !flush;
    g = -1;
    for (int k = 0; k < NS; k++) begin
      if (g < 0 && hv[(rr + k) % NS]) g = (rr + k) % NS;
    end
    push = (g >= 0) && ((q.size() < DEP) || pop) && !flush;
    set  = 1'b0;
    if (flush) begin
      q.delete();
      for (int i = 0; i < NS; i++) hv[i] = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back({2'(g), hr[g], he[g], hc[g]});
        rr = (g + 1) % NS;
      end
      for (int i = 0; i < NS; i++) begin
        if (src_strobe[i]) begin
          if (hv[i] && !(push && g == i)) set = 1'b1;
          else begin
            hv[i] = 1'b1; hc[i] = src_code[8*i +: 8]; he[i] = src_ext[i]; hr[i] = src_rel[i];
          end
        end else if (push && g == i) hv[i] = 1'b0;
      end
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_rdq = oe;
    m_wrq = kbw;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    bit [11:0] h;
    bit [7:0]  ekb;
    model_step();
    #1;
    h   = (q.size() > 0) ? q[0] : 12'h000;
    ekb = {q.size() == DEP, m_ovf, h[11:10], 1'b0, h[9], h[8], q.size() > 0};
    check("m_scancode", scancode_dout, h[7:0]);
    check("m_kbstatus", kbstatus_dout, ekb);
    check("m_pending", {7'd0, evt_pending}, {7'd0, q.size() > 0});
    check("m_oe_sc", {7'd0, oe_scancode}, {7'd0, (zxuno_addr == 8'h04) && zxuno_regrd});
    check("m_oe_kb", {7'd0, oe_kbstatus}, {7'd0, (zxuno_addr == 8'h05) && zxuno_regrd});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    src_strobe = 2'b00; src_code = 16'h0000; src_ext = 2'b00; src_rel = 2'b00;
    zxuno_addr = 8'h04; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0; din = 8'h00;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic strobe(int s, logic [7:0] code, logic e, logic r);
    src_strobe[s] = 1'b1; src_code[8*s +: 8] = code; src_ext[s] = e; src_rel[s] = r;
    tick();
    src_strobe = 2'b00;
  endtask

  task automatic read_sc(int n);
    zxuno_addr = 8'h04; zxuno_regrd = 1'b1;
    repeat (n) tick();
    zxuno_regrd = 1'b0;
    tick();
  endtask

  task automatic kb_write(logic [7:0] d);
    zxuno_addr = 8'h05; din = d; zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0; zxuno_addr = 8'h04; din = 8'h00;
  endtask

  task automatic rand_phase(int n, int p_strobe, int p_read);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NS; i++) src_strobe[i] = ($urandom_range(0, 99) < p_strobe);
      src_code = 16'($urandom);
      src_ext  = 2'($urandom);
      src_rel  = 2'($urandom);
      zxuno_regrd = ($urandom_range(0, 99) < p_read);
      case ($urandom_range(0, 3))
        0: zxuno_addr = 8'h05;
        1: zxuno_addr = 8'h06;
        default: zxuno_addr = 8'h04;
      endcase
      zxuno_regwr = ($urandom_range(0, 24) == 0);
      din    = 8'($urandom);
      din[7] = ($urandom_range(0, 7) == 0);
      rst_n  = ($urandom_range(0, 599) != 0);
      tick();
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset then idle
    reset_dut();
    check("rst_kbstatus", kbstatus_dout, 8'h00);
    check("rst_scancode", scancode_dout, 8'h00);
    check("rst_pending", {7'd0, evt_pending}, 8'h00);

    // Single event and a SCANCODE read that pops it
    strobe(0, 8'h1C, 1'b0, 1'b0);
    tick();
    check("single_sc", scancode_dout, 8'h1C);
    check("single_kb", kbstatus_dout, 8'h01);
    read_sc(3);
    check("single_popped", {7'd0, evt_pending}, 8'h00);

    // Two sources in the same cycle
    reset_dut();
    src_strobe = 2'b11; src_code = 16'h7416; src_ext = 2'b10; src_rel = 2'b10;
    tick();
    idle_inputs();
    tick();
    check("simul_first", scancode_dout, 8'h16);
    tick();
    read_sc(1);
    check("simul_second", scancode_dout, 8'h74);
    check("simul_kb", kbstatus_dout, 8'h17);

    // Fill to DEPTH, overflow, then drain in order
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      strobe(0, 8'h20 + 8'(i), 1'b0, 1'b0);
      tick(); tick();
    end
    check("full_kb", kbstatus_dout, 8'hC1);
    check("full_sc", scancode_dout, 8'h20);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", scancode_dout, 8'h20 + 8'(i));
      read_sc(1);
    end

    // Back-to-back strobes into a blocked holder, then clear OVF
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      strobe(0, 8'h30 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    src_strobe = 2'b01; src_code = 16'h0040;
    tick();
    src_code = 16'h0041;
    tick();
    idle_inputs();
    tick();
    check("hold_ovf_kb", kbstatus_dout, 8'hC1);
    kb_write(8'h40);
    check("ovf_clr_kb", kbstatus_dout, 8'h81);
    check("ovf_clr_sc", scancode_dout, 8'h30);

    // Interleaved push/pop across pointer wrap, then flush with a coincident strobe
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      strobe(1, 8'h50 + 8'(i), 1'b0, 1'b1);
      tick();
      check("wrap_sc", scancode_dout, 8'h50 + 8'(i));
      read_sc(1);
      check("wrap_empty", {7'd0, evt_pending}, 8'h00);
    end
    strobe(0, 8'h61, 1'b0, 1'b0);
    src_strobe = 2'b01; src_code = 16'h0099;
    kb_write(8'h80);
    idle_inputs();
    tick();
    check("flush_kb", kbstatus_dout, 8'h00);
    tick();
    check("flush_sc", scancode_dout, 8'h00);

    // Randomized traffic: balanced, then strobe-heavy to exercise full/overflow
    rand_phase(3000, 30, 40);
    rand_phase(2000, 60, 10);
    rand_phase(1000, 15, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
